// File: rtl/register_file.sv
// 32 x XLEN register file with x0 tied to zero, write bypass and a pending scoreboard for multi-cycle producers.
// Reads and hazards are combinational; writes, pending bits and counters update on the rising edge. No backpressure.
module register_file #(
  parameter int XLEN   = 32,
  parameter int BYPASS = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [4:0]      rs1Address,
  input  logic [4:0]      rs2Address,
  input  logic [4:0]      rdAddress,
  input  logic            rdWriteEnable,
  input  logic [XLEN-1:0] rdWriteData,
  input  logic            reserveEnable,
  input  logic            releaseEnable,
  input  logic [4:0]      releaseAddress,
  input  logic [XLEN-1:0] releaseData,
  output logic [XLEN-1:0] rs1Data,
  output logic [XLEN-1:0] rs2Data,
  output logic            rs1Hazard,
  output logic            rs2Hazard,
  output logic [5:0]      pendingCount,
  output logic            scoreboardError
);

  logic [XLEN-1:0] regs [0:31];
  logic [31:0]     pending;
  logic [31:0]     pending_next;
  logic [5:0]      pending_count;
  logic            scoreboard_error;

  logic wr_en;
  logic rsv_en;
  logic rel_en;
  logic rel_same_rd;
  logic cnt_inc;
  logic cnt_dec;
  logic err_rel;
  logic err_rsv;
  logic err_wr;

  // Operations on x0 are filtered out here so nothing downstream needs to care.
  assign wr_en       = rdWriteEnable && (rdAddress != 5'd0);
  assign rsv_en      = reserveEnable && (rdAddress != 5'd0);
  assign rel_en      = releaseEnable && (releaseAddress != 5'd0);
  assign rel_same_rd = rel_en && (releaseAddress == rdAddress);

  always_comb begin
    pending_next = pending;
    if (rel_en) pending_next[releaseAddress] = 1'b0;
    if (rsv_en) pending_next[rdAddress] = 1'b1;
  end

  // A reserve of the register being released leaves it pending, so that release does not decrement.
  assign cnt_inc = rsv_en && !pending[rdAddress];
  assign cnt_dec = rel_en && pending[releaseAddress] && !(rsv_en && rel_same_rd);

  assign err_rel = rel_en && !pending[releaseAddress];
  assign err_rsv = rsv_en && pending[rdAddress] && !rel_same_rd;
  assign err_wr  = wr_en && pending[rdAddress] && !rel_same_rd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
      pending          <= '0;
      pending_count    <= '0;
      scoreboard_error <= 1'b0;
    end else begin
      if (rel_en) regs[releaseAddress] <= releaseData;
      if (wr_en) regs[rdAddress] <= rdWriteData;
      pending       <= pending_next;
      pending_count <= pending_count + {5'd0, cnt_inc} - {5'd0, cnt_dec};
      if (err_rel || err_rsv || err_wr) scoreboard_error <= 1'b1;
    end
  end

  always_comb begin
    rs1Data = regs[rs1Address];
    if (BYPASS != 0 && rs1Address != 5'd0) begin
      if (wr_en && rdAddress == rs1Address) rs1Data = rdWriteData;
      else if (rel_en && releaseAddress == rs1Address) rs1Data = releaseData;
    end
    if (rs1Address == 5'd0) rs1Data = '0;
  end

  always_comb begin
    rs2Data = regs[rs2Address];
    if (BYPASS != 0 && rs2Address != 5'd0) begin
      if (wr_en && rdAddress == rs2Address) rs2Data = rdWriteData;
      else if (rel_en && releaseAddress == rs2Address) rs2Data = releaseData;
    end
    if (rs2Address == 5'd0) rs2Data = '0;
  end

  // Without bypass the released value is not visible yet, so the hazard must stand.
  assign rs1Hazard = (rs1Address != 5'd0) && pending[rs1Address] &&
                     !(BYPASS != 0 && rel_en && releaseAddress == rs1Address);
  assign rs2Hazard = (rs2Address != 5'd0) && pending[rs2Address] &&
                     !(BYPASS != 0 && rel_en && releaseAddress == rs2Address);

  assign pendingCount    = pending_count;
  assign scoreboardError = scoreboard_error;

endmodule

// File: tb/tb_register_file.sv
// Directed test of register_file with bypass enabled and disabled, both instances driven by the same stimulus.
module tb_register_file;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs1Address = '0, rs2Address = '0, rdAddress = '0, releaseAddress = '0;
  logic        rdWriteEnable = 1'b0, reserveEnable = 1'b0, releaseEnable = 1'b0;
  logic [31:0] rdWriteData = '0, releaseData = '0;

  logic [31:0] rs1Data, rs2Data, b0_rs1Data, b0_rs2Data;
  logic        rs1Hazard, rs2Hazard, b0_rs1Hazard, b0_rs2Hazard;
  logic [5:0]  pendingCount, b0_pendingCount;
  logic        scoreboardError, b0_scoreboardError;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  register_file #(.XLEN(32), .BYPASS(1)) dut (
    .clock(clock), .reset(reset),
    .rs1Address(rs1Address), .rs2Address(rs2Address), .rdAddress(rdAddress),
    .rdWriteEnable(rdWriteEnable), .rdWriteData(rdWriteData),
    .reserveEnable(reserveEnable), .releaseEnable(releaseEnable),
    .releaseAddress(releaseAddress), .releaseData(releaseData),
    .rs1Data(rs1Data), .rs2Data(rs2Data),
    .rs1Hazard(rs1Hazard), .rs2Hazard(rs2Hazard),
    .pendingCount(pendingCount), .scoreboardError(scoreboardError)
  );

  register_file #(.XLEN(32), .BYPASS(0)) dut_nobypass (
    .clock(clock), .reset(reset),
    .rs1Address(rs1Address), .rs2Address(rs2Address), .rdAddress(rdAddress),
    .rdWriteEnable(rdWriteEnable), .rdWriteData(rdWriteData),
    .reserveEnable(reserveEnable), .releaseEnable(releaseEnable),
    .releaseAddress(releaseAddress), .releaseData(releaseData),
    .rs1Data(b0_rs1Data), .rs2Data(b0_rs2Data),
    .rs1Hazard(b0_rs1Hazard), .rs2Hazard(b0_rs2Hazard),
    .pendingCount(b0_pendingCount), .scoreboardError(b0_scoreboardError)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; checks happen 2 ns after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    rdWriteEnable = 1'b0;
    reserveEnable = 1'b0;
    releaseEnable = 1'b0;
    rdAddress = '0;
    releaseAddress = '0;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst_count", 32'(pendingCount), 32'd0);
    check("rst_err", 32'(scoreboardError), 32'd0);
    #2 reset = 1'b1;
    tick();

    for (int i = 0; i < 32; i++) begin
      rs1Address = 5'(i);
      rs2Address = 5'(31 - i);
      settle();
      check("rst_rs1", rs1Data, 32'd0);
      check("rst_rs2", rs2Data, 32'd0);
      check("rst_haz", {30'd0, rs1Hazard, rs2Hazard}, 32'd0);
    end
    check("rst_count2", 32'(pendingCount), 32'd0);

    // Same-cycle write bypass
    tick();
    rdAddress = 5'd5; rdWriteEnable = 1'b1; rdWriteData = 32'hDEADBEEF; rs1Address = 5'd5;
    settle();
    check("byp_x5", rs1Data, 32'hDEADBEEF);
    check("nobyp_x5", b0_rs1Data, 32'd0);
    tick(); idle(); settle();
    check("x5_next", rs1Data, 32'hDEADBEEF);
    check("nobyp_x5_next", b0_rs1Data, 32'hDEADBEEF);

    // x0 ignores write and reserve
    rdAddress = 5'd0; rdWriteEnable = 1'b1; rdWriteData = 32'h12345678; reserveEnable = 1'b1;
    rs1Address = 5'd0;
    settle();
    check("x0_byp", rs1Data, 32'd0);
    tick(); idle(); settle();
    check("x0_rd", rs1Data, 32'd0);
    check("x0_count", 32'(pendingCount), 32'd0);
    check("x0_haz", 32'(rs1Hazard), 32'd0);
    check("x0_err", 32'(scoreboardError), 32'd0);

    // Reserve x7, x9; release x7
    rdAddress = 5'd7; reserveEnable = 1'b1;
    tick();
    rdAddress = 5'd9;
    tick(); idle();
    rs2Address = 5'd7;
    settle();
    check("cnt2", 32'(pendingCount), 32'd2);
    check("haz_x7", 32'(rs2Hazard), 32'd1);
    releaseEnable = 1'b1; releaseAddress = 5'd7; releaseData = 32'hA5A5A5A5;
    settle();
    check("rel_haz_mask", 32'(rs2Hazard), 32'd0);
    check("rel_byp", rs2Data, 32'hA5A5A5A5);
    check("nobyp_rel_haz", 32'(b0_rs2Hazard), 32'd1);
    check("nobyp_rel_data", b0_rs2Data, 32'd0);
    tick(); idle(); settle();
    check("cnt1", 32'(pendingCount), 32'd1);
    check("x7_val", rs2Data, 32'hA5A5A5A5);
    check("x7_haz", 32'(rs2Hazard), 32'd0);
    check("no_err1", 32'(scoreboardError), 32'd0);

    // Write and release of pending x3 in the same cycle
    rdAddress = 5'd3; reserveEnable = 1'b1;
    tick(); idle(); settle();
    check("cnt_x3", 32'(pendingCount), 32'd2);
    rdAddress = 5'd3; rdWriteEnable = 1'b1; rdWriteData = 32'h1111;
    releaseEnable = 1'b1; releaseAddress = 5'd3; releaseData = 32'h2222;
    rs1Address = 5'd3;
    settle();
    check("wr_wins_byp", rs1Data, 32'h1111);
    tick(); idle(); settle();
    check("wr_wins", rs1Data, 32'h1111);
    check("x3_cleared", 32'(rs1Hazard), 32'd0);
    check("cnt_after_x3", 32'(pendingCount), 32'd1);
    check("no_err2", 32'(scoreboardError), 32'd0);

    // Reserve and release of pending x9 in the same cycle: stays pending
    rdAddress = 5'd9; reserveEnable = 1'b1;
    releaseEnable = 1'b1; releaseAddress = 5'd9; releaseData = 32'h99;
    tick(); idle();
    rs1Address = 5'd9;
    settle();
    check("rsv_rel_cnt", 32'(pendingCount), 32'd1);
    check("rsv_rel_haz", 32'(rs1Hazard), 32'd1);
    check("rsv_rel_data", rs1Data, 32'h99);
    check("no_err3", 32'(scoreboardError), 32'd0);

    // Reserve x12 while releasing x9: count unchanged
    rdAddress = 5'd12; reserveEnable = 1'b1;
    releaseEnable = 1'b1; releaseAddress = 5'd9; releaseData = 32'h9;
    tick(); idle(); settle();
    check("swap_cnt", 32'(pendingCount), 32'd1);
    check("no_err4", 32'(scoreboardError), 32'd0);

    // Release of non-pending x4 is sticky error
    releaseEnable = 1'b1; releaseAddress = 5'd4; releaseData = 32'h4;
    tick(); idle(); settle();
    check("rel_np_err", 32'(scoreboardError), 32'd1);
    check("rel_np_cnt", 32'(pendingCount), 32'd1);
    tick(); tick();
    check("err_sticky", 32'(scoreboardError), 32'd1);

    // Reset while x10 is pending, then release x10
    rdAddress = 5'd10; reserveEnable = 1'b1; rdWriteEnable = 1'b1; rdWriteData = 32'h55;
    tick(); idle(); settle();
    check("cnt_x10", 32'(pendingCount), 32'd2);
    reset = 1'b0;
    rs1Address = 5'd10;
    settle();
    check("mid_rst_cnt", 32'(pendingCount), 32'd0);
    check("mid_rst_err", 32'(scoreboardError), 32'd0);
    check("mid_rst_x10", rs1Data, 32'd0);
    check("mid_rst_haz", 32'(rs1Hazard), 32'd0);
    reset = 1'b1;
    tick();
    releaseEnable = 1'b1; releaseAddress = 5'd10; releaseData = 32'h10;
    tick(); idle(); settle();
    check("post_rst_rel_err", 32'(scoreboardError), 32'd1);
    check("post_rst_rel_cnt", 32'(pendingCount), 32'd0);

    // Write to a pending register
    do_reset();
    rdAddress = 5'd2; reserveEnable = 1'b1;
    tick(); idle(); settle();
    check("wp_pre_err", 32'(scoreboardError), 32'd0);
    rdAddress = 5'd2; rdWriteEnable = 1'b1; rdWriteData = 32'h77;
    tick(); idle();
    rs1Address = 5'd2;
    settle();
    check("wp_err", 32'(scoreboardError), 32'd1);
    check("wp_data", rs1Data, 32'h77);
    check("wp_haz", 32'(rs1Hazard), 32'd1);

    // Double reserve
    do_reset();
    rdAddress = 5'd6; reserveEnable = 1'b1;
    tick(); settle();
    check("dr_pre_err", 32'(scoreboardError), 32'd0);
    tick(); idle(); settle();
    check("dr_err", 32'(scoreboardError), 32'd1);
    check("dr_cnt", 32'(pendingCount), 32'd1);
    check("nobyp_dr_cnt", 32'(b0_pendingCount), 32'd1);
    check("nobyp_dr_err", 32'(b0_scoreboardError), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
